dat_pts_serializer: RTL and testbench

DAT_PTS_SERIALIZER -- requirements
Module: dat_pts_serializer

---
 rtl/dat_phys_pkg.sv | 25 ++
 rtl/sd_crc16.sv | 28 ++
 rtl/dat_pts_serializer.sv | 131 +++++++++++++
 tb/tb_dat_pts_serializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dat_phys_pkg.sv
// Shared definitions for the SD DAT0 physical-layer serializer:
// frame geometry defaults, state encoding and the CRC-16-CCITT step.
package dat_phys_pkg;

    localparam int          DATA_W_DEF = 32;
    localparam int          CRC_W_DEF  = 16;
    localparam int          CNT_W      = 6;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADED,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_DONE
    } state_t;

    // One serial step of x^16+x^12+x^5+1, MSB-first, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC-16-CCITT accumulator: synchronous clear, advances one bit
// per enabled cycle.
module sd_crc16
    import dat_phys_pkg::*;
(
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge sd_clock) begin
        if (reset || clear) begin
            r_crc <= 16'h0000;
        end else if (enable) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/dat_pts_serializer.sv
// DAT0 parallel-to-serial framer: start bit, DATA_W payload bits MSB first,
// CRC-16 MSB first, stop bit. All pad-facing outputs are registered.
module dat_pts_serializer
    import dat_phys_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CRC_W  = CRC_W_DEF
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              enable_pts,
    input  logic              load_send,
    input  logic [DATA_W-1:0] data_in,
    output logic              dat_out,
    output logic              dat_oe,
    output logic              transmission_complete,
    output logic              busy
);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [15:0]        w_crc;
    logic [15:0]        w_crc_sh;
    logic               w_load;
    logic               w_crc_en;
    logic               w_dat_out_next;
    logic               w_drive_next;
    logic               r_dat_out;
    logic               r_dat_oe;
    logic               r_tc;
    logic               r_busy;

    assign w_load   = (r_state == ST_IDLE) && enable_pts;
    // The CRC consumes exactly the bit being launched onto the line, so it
    // is final by the time the first CRC bit must be registered.
    assign w_crc_en = (w_state_next == ST_DATA);

    sd_crc16 u_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (w_load),
        .enable   (w_crc_en),
        .bit_in   (r_shift[DATA_W-1]),
        .crc      (w_crc)
    );

    // NOTE: every combinational output is assigned a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (r_state != ST_IDLE && !enable_pts) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:   w_state_next = ST_LOADED;
                ST_LOADED: if (load_send) w_state_next = ST_START;
                ST_START:  w_state_next = ST_DATA;
                ST_DATA:   if (r_cnt == DATA_LAST) w_state_next = ST_CRC;
                ST_CRC:    if (r_cnt == CRC_LAST) w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_DONE;
                ST_DONE:   w_state_next = ST_DONE;
                default:   w_state_next = ST_IDLE;
            endcase
            if (r_state == ST_IDLE && !enable_pts) w_state_next = ST_IDLE;
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if (w_state_next == r_state) begin
            if ((r_state == ST_DATA && r_cnt != DATA_LAST) ||
                (r_state == ST_CRC  && r_cnt != CRC_LAST)) begin
                w_cnt_next = r_cnt + CNT_ONE;
            end else begin
                w_cnt_next = r_cnt;
            end
        end
    end

    // The CRC register holds still; the next counter value selects the bit.
    assign w_crc_sh = w_crc << w_cnt_next;

    always_comb begin
        w_dat_out_next = 1'b1;
        w_drive_next   = 1'b0;
        unique case (w_state_next)
            ST_START: begin w_dat_out_next = 1'b0;              w_drive_next = 1'b1; end
            ST_DATA:  begin w_dat_out_next = r_shift[DATA_W-1]; w_drive_next = 1'b1; end
            ST_CRC:   begin w_dat_out_next = w_crc_sh[15];      w_drive_next = 1'b1; end
            ST_STOP:  begin w_dat_out_next = 1'b1;              w_drive_next = 1'b1; end
            default:  begin w_dat_out_next = 1'b1;              w_drive_next = 1'b0; end
        endcase
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_dat_out <= 1'b1;
            r_dat_oe  <= 1'b0;
            r_tc      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_dat_out <= w_dat_out_next;
            r_dat_oe  <= w_drive_next;
            r_busy    <= w_drive_next;
            r_tc      <= (w_state_next == ST_DONE);
            if (w_load) begin
                r_shift <= data_in;
            end else if (w_state_next == ST_DATA) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign dat_out               = r_dat_out;
    assign dat_oe                = r_dat_oe;
    assign transmission_complete = r_tc;
    assign busy                  = r_busy;

endmodule

// File: tb/tb_dat_pts_serializer.sv
// Directed bench for dat_pts_serializer: table of full frames checked bit-exact,
// plus hand sequences for abort, mid-frame reset and load_send held in DONE.
module tb_dat_pts_serializer;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_pts = 1'b0;
    logic        load_send = 1'b0;
    logic [31:0] data_in = '0;
    logic        dat_out;
    logic        dat_oe;
    logic        transmission_complete;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] crc;
        string       name;
    } frame_vec_t;

    frame_vec_t vecs[5];

    dat_pts_serializer #(.DATA_W(32), .CRC_W(16)) dut (
        .sd_clock              (sd_clock),
        .reset                 (reset),
        .enable_pts            (enable_pts),
        .load_send             (load_send),
        .data_in               (data_in),
        .dat_out               (dat_out),
        .dat_oe                (dat_oe),
        .transmission_complete (transmission_complete),
        .busy                  (busy)
    );

    always #5 sd_clock = ~sd_clock;

    // Reference CRC as the remainder of polynomial long division of d*x^16.
    function automatic logic [15:0] crc_ref(input logic [31:0] d);
        logic [47:0] m;
        m = {d, 16'h0000};
        for (int i = 47; i >= 16; i--) begin
            if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h11021;
        end
        return m[15:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic check_quiet(input string name, input logic exp_tc);
        check({name, "_outs"}, {60'h0, dat_out, dat_oe, transmission_complete, busy},
              {60'h0, 1'b1, 1'b0, exp_tc, 1'b0});
    endtask

    // Starts in IDLE with enable_pts low; ends back in IDLE.
    task automatic run_frame(input logic [31:0] d, input logic [15:0] crc_exp, input string name);
        logic [49:0] got;
        int          oe_low;
        int          busy_low;
        int          tc_early;
        data_in    = d;
        enable_pts = 1'b1;
        step();
        check_quiet({name, "_loaded"}, 1'b0);
        load_send = 1'b1;
        step();                       // edge k
        load_send = 1'b0;
        got = '0; oe_low = 0; busy_low = 0; tc_early = 0;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) step();
            got = {got[48:0], dat_out};
            if (!dat_oe) oe_low++;
            if (!busy) busy_low++;
            if (transmission_complete) tc_early++;
        end
        check({name, "_start"}, {63'h0, got[49]}, 64'h0);
        check({name, "_data"}, {32'h0, got[48:17]}, {32'h0, d});
        check({name, "_crc"}, {48'h0, got[16:1]}, {48'h0, crc_exp});
        check({name, "_stop"}, {63'h0, got[0]}, 64'h1);
        check({name, "_oe_low_cycles"}, 64'(oe_low), 64'h0);
        check({name, "_busy_low_cycles"}, 64'(busy_low), 64'h0);
        check({name, "_tc_early"}, 64'(tc_early), 64'h0);
        step();                       // edge k+50
        check_quiet({name, "_done"}, 1'b1);
        enable_pts = 1'b0;
        step();
        check_quiet({name, "_idle"}, 1'b0);
    endtask

    initial begin
        int tc_seen;
        int bad;

        vecs[0] = '{32'h0000_0000, 16'h0000, "zeros"};
        vecs[1] = '{32'h0000_0001, 16'h1021, "one"};
        vecs[2] = '{32'hA5A5_A5A5, crc_ref(32'hA5A5_A5A5), "a5"};
        vecs[3] = '{32'hFFFF_FFFF, crc_ref(32'hFFFF_FFFF), "ones"};
        vecs[4] = '{32'h8000_0000, crc_ref(32'h8000_0000), "msb"};

        // Reset values.
        step();
        step();
        check_quiet("reset", 1'b0);
        reset = 1'b0;
        step();
        check_quiet("post_reset", 1'b0);

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].data, vecs[v].crc, vecs[v].name);
        end

        // Abort at DATA bit 10.
        data_in    = 32'h1234_5678;
        enable_pts = 1'b1;
        step();
        load_send = 1'b1;
        step();
        load_send = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (transmission_complete) tc_seen++;
        end
        check("abort_bit10_value", {63'h0, dat_out}, {63'h0, data_in[21]});
        enable_pts = 1'b0;
        step();
        check_quiet("abort_idle", 1'b0);
        for (int i = 0; i < 60; i++) begin
            step();
            if (transmission_complete || dat_oe) tc_seen++;
        end
        check("abort_no_tc", 64'(tc_seen), 64'h0);

        // Abort has priority over load_send in LOADED.
        data_in    = 32'hDEAD_BEEF;
        enable_pts = 1'b1;
        step();
        enable_pts = 1'b0;
        load_send  = 1'b1;
        step();
        check_quiet("loaded_abort_prio", 1'b0);
        step();
        check_quiet("loaded_abort_stays", 1'b0);
        load_send = 1'b0;

        // Reset during CRC bit 5, then a fresh frame.
        data_in    = 32'hA5A5_A5A5;
        enable_pts = 1'b1;
        step();
        load_send = 1'b1;
        step();                       // START
        load_send = 1'b0;
        for (int i = 0; i < 38; i++) step();
        check("crc_bit5_value", {63'h0, dat_out}, {63'h0, vecs[2].crc[10]});
        reset     = 1'b1;
        load_send = 1'b1;
        step();
        check_quiet("midframe_reset", 1'b0);
        reset      = 1'b0;
        load_send  = 1'b0;
        enable_pts = 1'b0;
        step();
        run_frame(32'h0000_0001, 16'h1021, "after_reset");

        // load_send held high in DONE must not restart a frame.
        data_in    = 32'h0F0F_0F0F;
        enable_pts = 1'b1;
        step();
        load_send = 1'b1;
        step();
        load_send = 1'b0;
        for (int i = 0; i < 50; i++) step();
        check_quiet("hold_done_entry", 1'b1);
        load_send = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (dat_oe || busy || !transmission_complete) bad++;
        end
        check("hold_done_no_refire", 64'(bad), 64'h0);
        enable_pts = 1'b0;
        step();
        check_quiet("hold_done_exit", 1'b0);
        load_send = 1'b0;
        step();
        check_quiet("hold_done_idle", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
